// File: rtl/hour_bcd_counter.sv
// BCD hours counter with RUN/SET modes.
// Counts 00..MAX_HOUR on the minutes carry, supports manual advance and
// direct load while in SET, and provides a 12-hour view with a PM flag.
// A day_pulse marks the wrap back to 00 caused by the minutes carry only.
module hour_bcd_counter #(
    parameter int MAX_HOUR   = 23,
    parameter int RESET_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc_pulse,
    input  logic       set_mode,
    input  logic       adj_pulse,
    input  logic       load_en,
    input  logic [1:0] load_ten,
    input  logic [3:0] load_unit,
    output logic [3:0] count_H_unit,
    output logic [1:0] count_H_ten,
    output logic       hr12_ten,
    output logic [3:0] hr12_unit,
    output logic       pm,
    output logic       day_pulse,
    output logic       load_err,
    output logic       in_set
);

    typedef enum logic {
        RUN = 1'b0,
        SET = 1'b1
    } state_t;

    localparam logic [1:0] RESET_TEN  = 2'(RESET_HOUR / 10);
    localparam logic [3:0] RESET_UNIT = 4'(RESET_HOUR % 10);
    localparam logic [5:0] MAX_VAL    = 6'(MAX_HOUR);

    state_t     state;
    logic [1:0] ten;
    logic [3:0] unit;
    logic [5:0] hour_val;
    logic [5:0] load_val;
    logic [5:0] h12_val;
    logic       at_max;
    logic       load_ok;
    logic [1:0] inc_ten;
    logic [3:0] inc_unit;

    // Binary views of the current and requested hour, used only for compares.
    assign hour_val = ({4'd0, ten} * 6'd10) + {2'd0, unit};
    assign load_val = ({4'd0, load_ten} * 6'd10) + {2'd0, load_unit};
    assign at_max   = (hour_val == MAX_VAL);
    assign load_ok  = (load_ten <= 2'd2) && (load_unit <= 4'd9) && (load_val <= MAX_VAL);

    // Next BCD value for a one-hour advance, wrapping after MAX_HOUR.
    always_comb begin
        inc_ten  = ten;
        inc_unit = unit;
        if (at_max) begin
            inc_ten  = 2'd0;
            inc_unit = 4'd0;
        end else if (unit == 4'd9) begin
            inc_unit = 4'd0;
            inc_ten  = ten + 2'd1;
        end else begin
            inc_unit = unit + 4'd1;
        end
    end

    // 12-hour decode of the registered hour: 00 shows as 12 AM, 12 as 12 PM.
    always_comb begin
        pm = (hour_val >= 6'd12);
        if (hour_val == 6'd0) begin
            h12_val = 6'd12;
        end else if (hour_val > 6'd12) begin
            h12_val = hour_val - 6'd12;
        end else begin
            h12_val = hour_val;
        end
        hr12_ten  = (h12_val >= 6'd10);
        hr12_unit = hr12_ten ? 4'(h12_val - 6'd10) : h12_val[3:0];
    end

    // Mode FSM, hour register and registered status pulses; actions use the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ten       <= RESET_TEN;
            unit      <= RESET_UNIT;
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            day_pulse <= 1'b0;
            load_err  <= 1'b0;
            case (state)
                RUN: begin
                    if (inc_pulse) begin
                        ten       <= inc_ten;
                        unit      <= inc_unit;
                        day_pulse <= at_max;
                    end
                    if (set_mode) begin
                        state <= SET;
                    end
                end
                SET: begin
                    // The minutes carry is deliberately dropped while setting.
                    if (load_en) begin
                        if (load_ok) begin
                            ten  <= load_ten;
                            unit <= load_unit;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end else if (adj_pulse) begin
                        ten  <= inc_ten;
                        unit <= inc_unit;
                    end
                    if (!set_mode) begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign count_H_ten  = ten;
    assign count_H_unit = unit;
    assign in_set       = (state == SET);

endmodule

// File: tb/tb_hour_bcd_counter.sv
// Self-checking bench for hour_bcd_counter: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a model.
module tb_hour_bcd_counter;

    localparam int MAX_HOUR   = 23;
    localparam int RESET_HOUR = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       inc_pulse;
    logic       set_mode;
    logic       adj_pulse;
    logic       load_en;
    logic [1:0] load_ten;
    logic [3:0] load_unit;
    logic [3:0] count_H_unit;
    logic [1:0] count_H_ten;
    logic       hr12_ten;
    logic [3:0] hr12_unit;
    logic       pm;
    logic       day_pulse;
    logic       load_err;
    logic       in_set;

    int checks   = 0;
    int failures = 0;

    // Reference model state: hour as a plain integer.
    int m_hour = RESET_HOUR;
    bit m_set  = 1'b0;
    bit m_day  = 1'b0;
    bit m_err  = 1'b0;

    always #5 clk = ~clk;

    hour_bcd_counter #(
        .MAX_HOUR  (MAX_HOUR),
        .RESET_HOUR(RESET_HOUR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inc_pulse   (inc_pulse),
        .set_mode    (set_mode),
        .adj_pulse   (adj_pulse),
        .load_en     (load_en),
        .load_ten    (load_ten),
        .load_unit   (load_unit),
        .count_H_unit(count_H_unit),
        .count_H_ten (count_H_ten),
        .hr12_ten    (hr12_ten),
        .hr12_unit   (hr12_unit),
        .pm          (pm),
        .day_pulse   (day_pulse),
        .load_err    (load_err),
        .in_set      (in_set)
    );

    typedef struct {
        bit         r;
        bit         inc;
        bit         sm;
        bit         adj;
        bit         ld;
        logic [1:0] lt;
        logic [3:0] lu;
        int         e_hour;
        int         e_h12;
        bit         e_pm;
        bit         e_day;
        bit         e_err;
        bit         e_set;
    } vec_t;

    function automatic logic [14:0] pack_exp(int hour, int h12, bit p, bit d, bit e, bit s);
        logic [14:0] v;
        v[14:13] = 2'(hour / 10);
        v[12:9]  = 4'(hour % 10);
        v[8]     = (h12 >= 10);
        v[7:4]   = 4'(h12 % 10);
        v[3]     = p;
        v[2]     = d;
        v[1]     = e;
        v[0]     = s;
        return v;
    endfunction

    function automatic int to12(int h);
        return (h % 12 == 0) ? 12 : h % 12;
    endfunction

    function automatic logic [14:0] model_exp();
        return pack_exp(m_hour, to12(m_hour), m_hour >= 12, m_day, m_err, m_set);
    endfunction

    task automatic check(string name, logic [14:0] exp);
        logic [14:0] act;
        act = {count_H_ten, count_H_unit, hr12_ten, hr12_unit, pm, day_pulse, load_err, in_set};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s [ten,unit,h12t,h12u,pm,day,err,set] actual=%b_%b_%b_%b_%b_%b_%b_%b expected=%b_%b_%b_%b_%b_%b_%b_%b",
                     name, act[14:13], act[12:9], act[8], act[7:4], act[3], act[2], act[1], act[0],
                     exp[14:13], exp[12:9], exp[8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic model_edge(bit r, bit inc, bit sm, bit adj, bit ld, int lt, int lu);
        if (r) begin
            m_hour = RESET_HOUR;
            m_set  = 1'b0;
            m_day  = 1'b0;
            m_err  = 1'b0;
        end else begin
            m_day = 1'b0;
            m_err = 1'b0;
            if (m_set) begin
                if (ld) begin
                    if (lt <= 2 && lu <= 9 && lt * 10 + lu <= MAX_HOUR) m_hour = lt * 10 + lu;
                    else m_err = 1'b1;
                end else if (adj) begin
                    m_hour = (m_hour + 1) % (MAX_HOUR + 1);
                end
            end else if (inc) begin
                m_day  = (m_hour == MAX_HOUR);
                m_hour = (m_hour + 1) % (MAX_HOUR + 1);
            end
            m_set = sm;
        end
    endtask

    task automatic cycle(bit r, bit inc, bit sm, bit adj, bit ld, logic [1:0] lt, logic [3:0] lu);
        rst       = r;
        inc_pulse = inc;
        set_mode  = sm;
        adj_pulse = adj;
        load_en   = ld;
        load_ten  = lt;
        load_unit = lu;
        @(posedge clk);
        model_edge(r, inc, sm, adj, ld, int'(lt), int'(lu));
        #1;
    endtask

    vec_t vecs[$];

    initial begin
        bit sm_lvl;

        //        r  inc sm adj ld  lt    lu     hour h12 pm day err set
        vecs.push_back('{1, 0, 0, 0, 0, 2'd0, 4'd0,   0, 12, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 2'd0, 4'd0,   0, 12, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd2, 4'd1,  21,  9, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd2, 4'd5,  21,  9, 1, 0, 1, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 2'd0, 4'd0,  21,  9, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd1, 4'd12, 21,  9, 1, 0, 1, 1});
        vecs.push_back('{0, 0, 1, 0, 0, 2'd0, 4'd0,  21,  9, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 1, 2'd1, 4'd2,  12, 12, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 0, 2'd0, 4'd0,  13,  1, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd3, 4'd0,  13,  1, 1, 0, 1, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd2, 4'd3,  23, 11, 1, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 1, 0, 2'd0, 4'd0,   0, 12, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd2, 4'd3,  23, 11, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 1, 0, 0, 2'd0, 4'd0,  23, 11, 1, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 2'd0, 4'd0,  23, 11, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 2'd0, 4'd0,   0, 12, 0, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 2'd0, 4'd0,   0, 12, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 0, 2'd0, 4'd0,   0, 12, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 2'd1, 4'd5,   0, 12, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 2'd0, 4'd0,   1,  1, 0, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd0, 4'd9,   1,  1, 0, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 1, 2'd0, 4'd9,   9,  9, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 2'd0, 4'd0,   9,  9, 0, 0, 0, 0});
        vecs.push_back('{0, 1, 0, 0, 0, 2'd0, 4'd0,  10, 10, 0, 0, 0, 0});

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].inc, vecs[i].sm, vecs[i].adj, vecs[i].ld, vecs[i].lt, vecs[i].lu);
            check($sformatf("vec%0d", i),
                  pack_exp(vecs[i].e_hour, vecs[i].e_h12, vecs[i].e_pm, vecs[i].e_day, vecs[i].e_err, vecs[i].e_set));
        end

        // Full day of minute carries from reset: steps 01..23 then 00 with one day_pulse.
        cycle(1, 0, 0, 0, 0, 2'd0, 4'd0);
        check("day_reset", pack_exp(0, 12, 0, 0, 0, 0));
        for (int n = 1; n <= 24; n++) begin
            int h;
            h = n % 24;
            cycle(0, 1, 0, 0, 0, 2'd0, 4'd0);
            check($sformatf("day_inc%0d", n), pack_exp(h, to12(h), h >= 12, n == 24, 0, 0));
        end
        cycle(0, 0, 0, 0, 0, 2'd0, 4'd0);
        check("day_pulse_once", pack_exp(0, 12, 0, 0, 0, 0));

        // Reset while in SET at hour 17 with set_mode held high.
        cycle(0, 0, 1, 0, 0, 2'd0, 4'd0);
        cycle(0, 0, 1, 0, 1, 2'd1, 4'd7);
        check("set17", pack_exp(17, 5, 1, 0, 0, 1));
        cycle(1, 0, 1, 0, 0, 2'd0, 4'd0);
        check("rst_in_set", pack_exp(0, 12, 0, 0, 0, 0));
        cycle(0, 0, 1, 0, 0, 2'd0, 4'd0);
        check("reenter_set", pack_exp(0, 12, 0, 0, 0, 1));

        // Randomized traffic against the model.
        cycle(1, 0, 0, 0, 0, 2'd0, 4'd0);
        check("rand_reset", model_exp());
        sm_lvl = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            bit r, inc, adj, ld;
            logic [1:0] lt;
            logic [3:0] lu;
            if ($urandom_range(0, 15) == 0) sm_lvl = ~sm_lvl;
            r   = ($urandom_range(0, 127) == 0);
            inc = ($urandom_range(0, 2) == 0);
            adj = ($urandom_range(0, 3) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            lt  = 2'($urandom_range(0, 3));
            lu  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            cycle(r, inc, sm_lvl, adj, ld, lt, lu);
            check($sformatf("rand%0d", k), model_exp());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
